// File: rtl/bch_error_correct_buf_pkg.sv
// Shared constants and helpers for the BCH correction buffer: state encoding,
// clog2 and the beat/width sizing functions used by every file of the block.
package bch_error_correct_buf_pkg;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_BURST = 1'b1
  } rd_state_t;

  function automatic int bch_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Width of an index counting 0..n-1, never narrower than one bit.
  function automatic int bch_width(input int n);
    return (n <= 2) ? 1 : bch_clog2(n);
  endfunction

  function automatic int bch_beats(input int data_bits, input int bits);
    return (data_bits + bits - 1) / bits;
  endfunction

endpackage

// File: rtl/bch_error_correct_buf_if.sv
// Stream bundle of the correction buffer: message input, Chien err stream and
// corrected output. master = surrounding pipeline, slave = the buffer.
interface bch_error_correct_buf_if #(
  parameter int BITS = 1
);
  logic            in_valid;
  logic            in_first;
  logic [BITS-1:0] in_data;
  logic            in_ready;
  logic            err_first;
  logic [BITS-1:0] err;
  logic            out_valid;
  logic            out_first;
  logic            out_last;
  logic [BITS-1:0] out_data;

  modport master (
    output in_valid, in_first, in_data, err_first, err,
    input  in_ready, out_valid, out_first, out_last, out_data
  );

  modport slave (
    input  in_valid, in_first, in_data, err_first, err,
    output in_ready, out_valid, out_first, out_last, out_data
  );
endinterface

// File: rtl/bch_correct_ram.sv
// Simple dual-port codeword store: one write port, registered read port.
// The array is not reset; the surrounding control decides what is valid.
module bch_correct_ram #(
  parameter int DEPTH = 10,
  parameter int WIDTH = 1,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/bch_error_correct_buf.sv
// Buffers message beats per codeword and XORs the Chien err stream onto them.
// Optional BCH_CORRECT_COUNT_EN adds err_count (popcount of err per codeword).
module bch_error_correct_buf
  import bch_error_correct_buf_pkg::*;
#(
  parameter int DATA_BITS = 5,
  parameter int BITS      = 1,
  parameter int BUFFERS   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  bch_error_correct_buf_if.slave   bus,
  output logic                     proto_err
`ifdef BCH_CORRECT_COUNT_EN
  ,
  output logic [bch_clog2(DATA_BITS+1)-1:0] err_count
`endif
);
  localparam int W      = bch_beats(DATA_BITS, BITS);
  localparam int SLOT_W = bch_width(BUFFERS);
  localparam int BEAT_W = bch_width(W);
  localparam int FULL_W = bch_clog2(BUFFERS + 1);
  localparam int DEPTH  = BUFFERS * W;
  localparam int AW     = bch_width(DEPTH);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(BUFFERS - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(W - 1);
  localparam logic [FULL_W-1:0] FULL_MAX  = FULL_W'(BUFFERS);
  localparam logic [AW-1:0]     W_A       = AW'(W);

  function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
    return (s == SLOT_LAST) ? '0 : s + 1'b1;
  endfunction

  logic              wr_active;
  logic [BEAT_W-1:0] wr_beat, wr_idx;
  logic [SLOT_W-1:0] wr_slot, rd_slot;
  logic [FULL_W-1:0] full_cnt;
  logic              wr_en, commit, proto_wr;
  rd_state_t         state, state_nxt;
  logic [BEAT_W-1:0] rd_beat, rd_beat_nxt, rd_idx;
  logic              vld_p0, first_p0, last_p0, proto_rd;
  logic              vld_p1, first_p1, last_p1;
  logic [BITS-1:0]   err_p1, rd_q;

  assign bus.in_ready = !((full_cnt == FULL_MAX) && !wr_active);

  // Write side: a stray beat is dropped, a new in_first restarts the slot.
  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = '0;
    proto_wr = 1'b0;
    if (bus.in_valid && bus.in_ready) begin
      if (bus.in_first) begin
        wr_en    = 1'b1;
        proto_wr = wr_active;
      end else if (wr_active) begin
        wr_en  = 1'b1;
        wr_idx = wr_beat;
      end else begin
        proto_wr = 1'b1;
      end
    end
    commit = wr_en && (wr_idx == BEAT_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_active <= 1'b0;
      wr_beat   <= '0;
      wr_slot   <= '0;
    end else if (wr_en) begin
      if (commit) begin
        wr_active <= 1'b0;
        wr_beat   <= '0;
        wr_slot   <= next_slot(wr_slot);
      end else begin
        wr_active <= 1'b1;
        wr_beat   <= wr_idx + 1'b1;
      end
    end
  end

  // Stage p0: read FSM issues the RAM address in the same cycle as the err beat.
  always_comb begin
    state_nxt   = state;
    rd_beat_nxt = rd_beat;
    rd_idx      = rd_beat;
    vld_p0      = 1'b0;
    first_p0    = 1'b0;
    proto_rd    = 1'b0;
    case (state)
      RD_IDLE: begin
        if (bus.err_first) begin
          if (full_cnt != '0) begin
            vld_p0      = 1'b1;
            first_p0    = 1'b1;
            rd_idx      = '0;
            state_nxt   = RD_BURST;
            rd_beat_nxt = BEAT_W'(1);
          end else begin
            proto_rd = 1'b1;
          end
        end
      end
      RD_BURST: begin
        vld_p0      = 1'b1;
        proto_rd    = bus.err_first;
        rd_beat_nxt = rd_beat + 1'b1;
      end
      default: state_nxt = RD_IDLE;
    endcase
    last_p0 = vld_p0 && (rd_idx == BEAT_LAST);
    if (last_p0) begin
      state_nxt   = RD_IDLE;
      rd_beat_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RD_IDLE;
      rd_beat   <= '0;
      rd_slot   <= '0;
      full_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_beat   <= rd_beat_nxt;
      proto_err <= proto_err | proto_wr | proto_rd;
      if (last_p0) rd_slot <= next_slot(rd_slot);
      case ({commit, last_p0})
        2'b10:   full_cnt <= full_cnt + 1'b1;
        2'b01:   full_cnt <= full_cnt - 1'b1;
        default: full_cnt <= full_cnt;
      endcase
    end
  end

  bch_correct_ram #(
    .DEPTH (DEPTH),
    .WIDTH (BITS),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (AW'(wr_slot) * W_A + AW'(wr_idx)),
    .wr_data (bus.in_data),
    .rd_en   (vld_p0),
    .rd_addr (AW'(rd_slot) * W_A + AW'(rd_idx)),
    .rd_data (rd_q)
  );

  // Stage p1: RAM word and delayed err meet at the output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
    end else begin
      vld_p1   <= vld_p0;
      first_p1 <= first_p0;
      last_p1  <= last_p0;
    end
  end

  always_ff @(posedge clk) begin
    err_p1 <= bus.err;
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_first = first_p1;
  assign bus.out_last  = last_p1;
  assign bus.out_data  = vld_p1 ? (rd_q ^ err_p1) : '0;

`ifdef BCH_CORRECT_COUNT_EN
  localparam int CNT_W = bch_clog2(DATA_BITS + 1);

  function automatic logic [CNT_W-1:0] popcount(input logic [BITS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < BITS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  logic [CNT_W-1:0] acc_p0, sum_p0;

  assign sum_p0 = (first_p0 ? '0 : acc_p0) + popcount(bus.err);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_p0    <= '0;
      err_count <= '0;
    end else if (vld_p0) begin
      acc_p0 <= sum_p0;
      if (last_p0) err_count <= sum_p0;
    end
  end
`endif

endmodule

// File: tb/tb_bch_error_correct_buf.sv
// Bench for bch_error_correct_buf (DATA_BITS=5, BITS=1, BUFFERS=2): word-level
// queue model checked every cycle plus literal expectations per scenario.
module tb_bch_error_correct_buf;
  localparam int DATA_BITS = 5;
  localparam int BITS      = 1;
  localparam int BUFFERS   = 2;
  localparam int W         = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bch_error_correct_buf_if #(.BITS(BITS)) bus ();
  logic proto_err;
`ifdef BCH_CORRECT_COUNT_EN
  logic [2:0] err_count;
`endif

  bch_error_correct_buf #(
    .DATA_BITS (DATA_BITS),
    .BITS      (BITS),
    .BUFFERS   (BUFFERS)
  ) dut (
    .clk       (clk),
    .reset     (rst),
    .bus       (bus.slave),
    .proto_err (proto_err)
`ifdef BCH_CORRECT_COUNT_EN
    ,
    .err_count (err_count)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: committed words in a queue, partial word, burst progress.
  logic [W-1:0] mq [$];
  logic [W-1:0] m_part_word = '0;
  int  m_wr_beat = 0;
  int  m_rd_beat = 0;
  bit  m_part = 0;
  bit  m_busy = 0;
  bit  m_proto = 0;
  bit  exp_valid = 0, exp_first = 0, exp_last = 0, exp_data = 0;
  bit  exp_ready = 1;
`ifdef BCH_CORRECT_COUNT_EN
  int  m_cnt = 0;
  int  exp_cnt = 0;
`endif

  always @(posedge clk or posedge rst) begin
    bit ready_pre;
    bit done;
    if (rst) begin
      mq.delete();
      m_part = 0; m_busy = 0; m_proto = 0; m_wr_beat = 0; m_rd_beat = 0;
      exp_valid = 0; exp_first = 0; exp_last = 0; exp_data = 0; exp_ready = 1;
`ifdef BCH_CORRECT_COUNT_EN
      m_cnt = 0; exp_cnt = 0;
`endif
    end else begin
      ready_pre = !(mq.size() == BUFFERS && !m_part);
      done = 0;
      exp_valid = 0; exp_first = 0; exp_last = 0; exp_data = 0;
      if (!m_busy) begin
        if (bus.err_first) begin
          if (mq.size() > 0) begin
            m_busy = 1; m_rd_beat = 0;
`ifdef BCH_CORRECT_COUNT_EN
            m_cnt = 0;
`endif
          end else m_proto = 1;
        end
      end else if (bus.err_first) m_proto = 1;
      if (m_busy) begin
        exp_valid = 1;
        exp_first = (m_rd_beat == 0);
        exp_last  = (m_rd_beat == W - 1);
        exp_data  = mq[0][m_rd_beat] ^ bus.err[0];
`ifdef BCH_CORRECT_COUNT_EN
        m_cnt += int'(bus.err[0]);
        if (m_rd_beat == W - 1) exp_cnt = m_cnt;
`endif
        if (m_rd_beat == W - 1) done = 1;
        m_rd_beat++;
      end
      if (bus.in_valid && ready_pre) begin
        if (bus.in_first) begin
          if (m_part) m_proto = 1;
          m_part = 1; m_wr_beat = 0;
        end else if (!m_part) m_proto = 1;
        if (m_part) begin
          m_part_word[m_wr_beat] = bus.in_data[0];
          m_wr_beat++;
          if (m_wr_beat == W) begin
            mq.push_back(m_part_word);
            m_part = 0;
          end
        end
      end
      if (done) begin
        void'(mq.pop_front());
        m_busy = 0;
      end
      exp_ready = !(mq.size() == BUFFERS && !m_part);
    end
  end

  // Every output sample is {first,last,data}, kept for literal checks.
  int cap [$];

  always @(posedge clk) begin
    #1;
    check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
    check("out_first", 32'(bus.out_first), 32'(exp_first));
    check("out_last", 32'(bus.out_last), 32'(exp_last));
    if (exp_valid) check("out_data", 32'(bus.out_data), 32'(exp_data));
    check("proto_err", 32'(proto_err), 32'(m_proto));
`ifdef BCH_CORRECT_COUNT_EN
    check("err_count", 32'(err_count), 32'(exp_cnt));
`endif
    if (bus.out_valid) cap.push_back(int'({bus.out_first, bus.out_last, bus.out_data[0]}));
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_beat(input bit f, input bit d);
    int guard;
    guard = 0;
    bus.in_valid = 1'b0;
    while (!bus.in_ready && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      checks++; failures++;
      $display("FAIL in_ready_timeout actual=0 expected=1 at %0t", $time);
    end
    bus.in_valid = 1'b1;
    bus.in_first = f;
    bus.in_data  = d;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
  endtask

  task automatic write_word(input logic [W-1:0] w, input int n);
    for (int i = 0; i < n; i++) drive_beat(i == 0, w[i]);
  endtask

  task automatic err_burst(input logic [W-1:0] e);
    bus.err_first = 1'b1;
    bus.err       = e[0];
    @(negedge clk);
    bus.err_first = 1'b0;
    for (int i = 1; i < W; i++) begin
      bus.err = e[i];
      @(negedge clk);
    end
    bus.err = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_data = 1'b0;
    bus.err_first = 1'b0; bus.err = 1'b0;
    idle(2);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    idle(1);

    // Basic correction: 1,0,1,1,0 ^ 0,0,1,0,0 = 1,0,0,1,0
    cap.delete();
    write_word(5'b01101, W);
    err_burst(5'b00100);
    idle(2);
    check("t1_count", 32'(cap.size()), 32'd5);
    if (cap.size() == 5) begin
      check("t1_b0", 32'(cap[0]), 32'd5);
      check("t1_b1", 32'(cap[1]), 32'd0);
      check("t1_b2", 32'(cap[2]), 32'd0);
      check("t1_b3", 32'(cap[3]), 32'd1);
      check("t1_b4", 32'(cap[4]), 32'd2);
    end

    // err_first with nothing buffered
    cap.delete();
    bus.err_first = 1'b1;
    @(negedge clk);
    bus.err_first = 1'b0;
    idle(3);
    check("t2_no_out", 32'(cap.size()), 32'd0);
    check("t2_proto", 32'(proto_err), 32'd1);
    pulse_reset();
    check("t2_proto_clr", 32'(proto_err), 32'd0);

    // Two words fill the buffer; the third stalls until the first burst ends
    cap.delete();
    write_word(5'b10011, W);
    write_word(5'b01010, W);
    check("t3_full", 32'(bus.in_ready), 32'd0);
    fork
      write_word(5'b11100, W);
      begin
        err_burst(5'b00001);
        err_burst(5'b10000);
      end
    join
    err_burst(5'b00110);
    idle(2);
    check("t3_count", 32'(cap.size()), 32'd15);

    // Burst completion coincides with the next word's commit
    cap.delete();
    write_word(5'b00111, W);
    fork
      write_word(5'b11001, W);
      err_burst(5'b01000);
    join
    err_burst(5'b00010);
    idle(2);
    check("t4_count", 32'(cap.size()), 32'd10);
    check("t4_proto", 32'(proto_err), 32'd0);

    // Restart after two beats: 0,1,1,0,1 ^ 1,0,0,0,0 = 1,1,1,0,1
    cap.delete();
    write_word(5'b00011, 2);
    write_word(5'b10110, W);
    err_burst(5'b00001);
    idle(2);
    check("t5_proto", 32'(proto_err), 32'd1);
    check("t5_count", 32'(cap.size()), 32'd5);
    if (cap.size() == 5) begin
      check("t5_b0", 32'(cap[0]), 32'd5);
      check("t5_b3", 32'(cap[3]), 32'd0);
      check("t5_b4", 32'(cap[4]), 32'd3);
    end
    pulse_reset();

    // All-ones word with err 1,1,0,0,1 -> 0,0,1,1,0, three errors
    cap.delete();
    write_word(5'b11111, W);
    err_burst(5'b10011);
    idle(2);
    check("t6_count", 32'(cap.size()), 32'd5);
    if (cap.size() == 5) begin
      check("t6_b0", 32'(cap[0]), 32'd4);
      check("t6_b2", 32'(cap[2]), 32'd1);
      check("t6_b4", 32'(cap[4]), 32'd2);
    end
`ifdef BCH_CORRECT_COUNT_EN
    check("t6_err_count", 32'(err_count), 32'd3);
`endif

    // Asynchronous reset in the middle of a burst
    write_word(5'b10101, W);
    fork
      err_burst(5'b11111);
      begin
        idle(2);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        check("t6_rst_data", 32'(bus.out_data), 32'd0);
        check("t6_rst_ready", 32'(bus.in_ready), 32'd1);
`ifdef BCH_CORRECT_COUNT_EN
        check("t6_rst_count", 32'(err_count), 32'd0);
`endif
      end
    join
    rst = 1'b0;
    cap.delete();
    idle(2);
    check("t6_quiet", 32'(cap.size()), 32'd0);
    write_word(5'b01100, W);
    err_burst(5'b00100);
    idle(2);
    check("t6_recover", 32'(cap.size()), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
